fib_tx_streamer: RTL and testbench

FIB_TX_STREAMER -- requirements
Module: fib_tx_streamer

---
 rtl/fib_pkg.sv | 38 +++
 rtl/fib_tx_streamer_bin2bcd.sv | 53 +++++
 rtl/fib_tx_streamer.sv | 147 ++++++++++++++
 tb/tb_fib_tx_streamer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci ASCII streamer.
// Holds FSM encodings, ASCII bytes and the term-count default.
package fib_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    SEND,
    WAIT,
    NEXT
  } state_t;

  typedef enum logic [1:0] {
    PH_DIG,
    PH_CR,
    PH_LF
  } phase_t;

  localparam int MAX_N_DEF = 24;
  localparam int NDIG      = 5;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Most significant nonzero digit; ones digit when the value is zero.
  function automatic logic [2:0] msd_idx(
    input logic [4*NDIG-1:0] d
  );
    msd_idx = 3'd0;
    for (int i = 1; i < NDIG; i++) begin
      if (d[4*i +: 4] != 4'd0) begin
        msd_idx = 3'(i);
      end
    end
  endfunction

endpackage

// File: rtl/fib_tx_streamer_bin2bcd.sv
// Iterative double-dabble converter, one shift per clock.
// The first shift happens on the load edge so done lands W cycles later.
module bin2bcd
  import fib_pkg::*;
#(
  parameter int W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bcd_start,
  input  logic [W-1:0]      bin,
  output logic              bcd_done,
  output logic [4*NDIG-1:0] bcd
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]      sh;
  logic [CW-1:0]     cnt;
  logic [4*NDIG-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd      <= '0;
      sh       <= '0;
      cnt      <= '0;
      bcd_done <= 1'b0;
    end else begin
      bcd_done <= 1'b0;
      if (bcd_start) begin
        bcd      <= {{(4*NDIG-1){1'b0}}, bin[W-1]};
        sh       <= bin << 1;
        cnt      <= CW'(W - 1);
        bcd_done <= (W == 1);
      end else if (cnt != '0) begin
        bcd      <= {adj[4*NDIG-2:0], sh[W-1]};
        sh       <= sh << 1;
        cnt      <= cnt - 1'b1;
        bcd_done <= (cnt == CW'(1));
      end
    end
  end

endmodule

// File: rtl/fib_tx_streamer.sv
// Streams Fibonacci terms as decimal ASCII lines to a UART transmitter.
// One byte in flight at a time; each term is converted via bin2bcd.
module fib_tx_streamer
  import fib_pkg::*;
#(
  parameter int W     = 16,
  parameter int MAX_N = MAX_N_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [4:0] n,
  input  logic       tx_done_tick,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done_tick
);

  state_t            state;
  phase_t            phase;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic [4:0]        idx;
  logic [4:0]        n_lat;
  logic [4:0]        n_clamp;
  logic [2:0]        ptr;
  logic [2:0]        ptr_m1;
  logic [2:0]        msd;
  logic [3:0]        msd_dig;
  logic [3:0]        lo_dig;
  logic              bcd_start;
  logic              bcd_done;
  logic [4*NDIG-1:0] bcd;

  bin2bcd #(
    .W(W)
  ) u_bcd (
    .clk      (clk),
    .reset_n  (reset_n),
    .bcd_start(bcd_start),
    .bin      (a),
    .bcd_done (bcd_done),
    .bcd      (bcd)
  );

  always_comb begin
    n_clamp = (n > 5'(MAX_N)) ? 5'(MAX_N) : n;
    ptr_m1  = ptr - 3'd1;
    msd     = msd_idx(bcd);
    msd_dig = bcd[4*msd +: 4];
    lo_dig  = bcd[4*ptr_m1 +: 4];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      phase     <= PH_DIG;
      a         <= '0;
      b         <= '0;
      idx       <= '0;
      n_lat     <= '0;
      ptr       <= '0;
      bcd_start <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      done_tick <= 1'b0;
      bcd_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (n_clamp == 5'd0) begin
              done_tick <= 1'b1;
            end else begin
              n_lat     <= n_clamp;
              a         <= '0;
              b         <= W'(1);
              idx       <= '0;
              busy      <= 1'b1;
              bcd_start <= 1'b1;
              state     <= CONV;
            end
          end
        end
        CONV: begin
          if (bcd_done) begin
            ptr      <= msd;
            phase    <= PH_DIG;
            tx_data  <= ASCII_0 | {4'h0, msd_dig};
            tx_start <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done_tick) begin
            unique case (phase)
              PH_DIG: begin
                tx_start <= 1'b1;
                state    <= SEND;
                if (ptr != 3'd0) begin
                  ptr     <= ptr_m1;
                  tx_data <= ASCII_0 | {4'h0, lo_dig};
                end else begin
                  phase   <= PH_CR;
                  tx_data <= ASCII_CR;
                end
              end
              PH_CR: begin
                phase    <= PH_LF;
                tx_data  <= ASCII_LF;
                tx_start <= 1'b1;
                state    <= SEND;
              end
              default: begin
                state <= NEXT;
              end
            endcase
          end
        end
        NEXT: begin
          a   <= b;
          b   <= a + b;
          idx <= idx + 5'd1;
          if (idx == n_lat - 5'd1) begin
            done_tick <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            bcd_start <= 1'b1;
            state     <= CONV;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_tx_streamer.sv
// Self-checking bench: vector table plus a byte scoreboard fed by a
// Fibonacci model and drained by a UART done-tick model.
module tb_fib_tx_streamer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [4:0] n = 5'd0;
  logic       tx_done_tick = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       done_tick;

  int checks = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  typedef struct {
    int n;
    int dly;
    int nbytes;
    int poke;
    bit spur;
  } vec_t;

  vec_t vecs[8];

  fib_tx_streamer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .n           (n),
    .tx_done_tick(tx_done_tick),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .busy        (busy),
    .done_tick   (done_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: got event required none", name);
  endtask

  task automatic push_model(input int nn);
    int fa;
    int fb;
    int t;
    string s;
    if (nn > 24) nn = 24;
    fa = 0;
    fb = 1;
    for (int k = 0; k < nn; k++) begin
      s = $sformatf("%0d", fa);
      for (int j = 0; j < s.len(); j++) exp_q.push_back(s[j]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      t = fa + fb;
      fa = fb;
      fb = t;
    end
  endtask

  task automatic run_seq(input int nn, input int dly, input int nbytes,
                         input int poke, input bit spur);
    int cyc;
    int cnt;
    int first;
    int done_at;
    int cd;
    bit outst;
    logic [7:0] tail[7];
    tail = '{8'h32, 8'h38, 8'h36, 8'h35, 8'h37, 8'h0D, 8'h0A};
    cyc = 0;
    cnt = 0;
    first = -1;
    done_at = -1;
    cd = 0;
    outst = 1'b0;
    exp_q.delete();
    got_q.delete();
    push_model(nn);
    @(posedge clk);
    #1;
    start = 1'b1;
    n = 5'(nn);
    while (done_at < 0 && cyc < 30000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (poke > 0 && cyc == poke);
      n = start ? 5'd3 : 5'(nn);
      tx_done_tick = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          tx_done_tick = 1'b1;
          outst = 1'b0;
        end
      end
      if (spur && cyc == 5) tx_done_tick = 1'b1;
      if (cyc == 1) check("busy_after_start", 32'(busy), 32'(nn != 0));
      if (tx_start) begin
        check("no_overlap", 32'(outst), 0);
        outst = 1'b1;
        cd = dly;
        cnt++;
        if (first < 0) first = cyc;
        got_q.push_back(tx_data);
        if (exp_q.size() == 0) fail_now("extra_byte");
        else check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (done_tick) begin
        done_at = cyc;
        check("busy_at_done", 32'(busy), 0);
      end
    end
    start = 1'b0;
    tx_done_tick = 1'b0;
    if (done_at < 0) fail_now("done_timeout");
    check("byte_count", 32'(cnt), 32'(nbytes));
    check("queue_empty", 32'(exp_q.size()), 0);
    if (nn > 0) check("first_tx_latency", 32'(first), 18);
    else check("zero_done_latency", 32'(done_at), 1);
    if (nn >= 24) begin
      if (got_q.size() < 7) fail_now("short_stream");
      else for (int j = 0; j < 7; j++)
        check("last_term", 32'(got_q[got_q.size() - 7 + j]), 32'(tail[j]));
    end
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done_tick), 0);
    check("busy_after_done", 32'(busy), 0);
  endtask

  task automatic reset_mid_stream();
    int cyc;
    int cnt;
    int cd;
    int seen;
    cyc = 0;
    cnt = 0;
    cd = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    n = 5'd5;
    while (cnt < 7 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      tx_done_tick = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) tx_done_tick = 1'b1;
      end
      if (tx_start) begin
        cnt++;
        cd = 1;
      end
    end
    if (cnt < 7) fail_now("third_term_timeout");
    check("third_term_byte", 32'(tx_data), 32'h31);
    reset_n = 1'b0;
    tx_done_tick = 1'b0;
    #1;
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done_tick", 32'(done_tick), 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (tx_start || done_tick) seen++;
    end
    check("quiet_after_reset", 32'(seen), 0);
  endtask

  initial begin
    vecs[0] = '{1, 1, 3, 0, 1'b0};
    vecs[1] = '{8, 1, 25, 0, 1'b0};
    vecs[2] = '{8, 160, 25, 0, 1'b0};
    vecs[3] = '{0, 1, 0, 0, 1'b0};
    vecs[4] = '{5, 1, 15, 40, 1'b0};
    vecs[5] = '{2, 1, 6, 0, 1'b1};
    vecs[6] = '{24, 1, 111, 0, 1'b0};
    vecs[7] = '{31, 160, 111, 0, 1'b0};

    #1;
    reset_n = 1'b0;
    #2;
    check("init_tx_start", 32'(tx_start), 0);
    check("init_tx_data", 32'(tx_data), 0);
    check("init_busy", 32'(busy), 0);
    check("init_done_tick", 32'(done_tick), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int v = 0; v < 8; v++)
      run_seq(vecs[v].n, vecs[v].dly, vecs[v].nbytes,
              vecs[v].poke, vecs[v].spur);

    reset_mid_stream();
    run_seq(2, 1, 6, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
